dmem_arbiter: RTL

Two-port arbiter that shares the single data memory between the CPU load/store path (port 0) and a debug/loader master (port 1). It picks one access per cycle with round-robin fairness and an optional bounded lock for back-to-back bursts. It drives the memory address, write-enable and read-enable lines, and returns registered read data to the winning port one cycle after acceptance. It sits between the CPU datapath and Data_Memory.

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arb_pick.sv | 37 +++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// No logic; state encodings and port indices only.
package dmem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_OWN0 = 2'd1;
    localparam state_t ST_OWN1 = 2'd2;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selector: owner with lock budget, else single requester, else round-robin.
// Latency 0; a requester is simply not granted when it loses (req stays held).
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = 4,
    parameter int CNT_W    = 3
) (
    input  logic [1:0]       req_i,
    input  state_t           state_i,
    input  logic             last_i,
    input  logic [CNT_W-1:0] lock_cnt_i,
    output logic [1:0]       gnt_o
);

    logic under_lim;

    assign under_lim = (lock_cnt_i < CNT_W'(MAX_LOCK));

    always_comb begin
        gnt_o = 2'b00;
        if (state_i == ST_OWN0 && req_i[PORT_CPU] && (!req_i[PORT_DBG] || under_lim)) begin
            gnt_o[PORT_CPU] = 1'b1;
        end else if (state_i == ST_OWN1 && req_i[PORT_DBG] && (!req_i[PORT_CPU] || under_lim)) begin
            gnt_o[PORT_DBG] = 1'b1;
        end else if (req_i == 2'b01) begin
            gnt_o[PORT_CPU] = 1'b1;
        end else if (req_i == 2'b10) begin
            gnt_o[PORT_DBG] = 1'b1;
        end else if (req_i == 2'b11) begin
            // Tie goes to whichever port was not served last (also covers forced handoff).
            if (last_i) gnt_o[PORT_CPU] = 1'b1;
            else        gnt_o[PORT_DBG] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU port 0, debug/loader port 1) with bounded lock.
// Grant latency 0, read data 1 cycle after acceptance; losers hold req until granted.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              req1_i,
    input  logic              we0_i,
    input  logic              we1_i,
    input  logic              lock0_i,
    input  logic              lock1_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, cnt_inc;
    logic             rvalid0_q, rvalid1_q, rvalid0_d, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [1:0]       gnt_raw, gnt;

    dmem_arb_pick #(
        .MAX_LOCK (MAX_LOCK),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req_i      ({req1_i, req0_i}),
        .state_i    (state_q),
        .last_i     (last_q),
        .lock_cnt_i (lock_cnt_q),
        .gnt_o      (gnt_raw)
    );

    assign gnt    = rst_i ? 2'b00 : gnt_raw;
    assign gnt0_o = gnt[PORT_CPU];
    assign gnt1_o = gnt[PORT_DBG];

    assign mem_addr_o  = gnt[PORT_CPU] ? addr0_i  : (gnt[PORT_DBG] ? addr1_i  : '0);
    assign mem_wdata_o = gnt[PORT_CPU] ? wdata0_i : (gnt[PORT_DBG] ? wdata1_i : '0);
    assign mem_we_o    = (gnt[PORT_CPU] & we0_i)  | (gnt[PORT_DBG] & we1_i);
    assign mem_re_o    = (gnt[PORT_CPU] & ~we0_i) | (gnt[PORT_DBG] & ~we1_i);

    assign rvalid0_d = gnt[PORT_CPU] & ~we0_i;
    assign rvalid1_d = gnt[PORT_DBG] & ~we1_i;

    assign cnt_inc = (lock_cnt_q == CNT_W'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        last_d     = last_q;
        if (gnt[PORT_CPU]) last_d = 1'b0;
        if (gnt[PORT_DBG]) last_d = 1'b1;
        // Count restarts at 1 whenever ownership is freshly taken.
        if (gnt[PORT_CPU] && lock0_i) begin
            state_d    = ST_OWN0;
            lock_cnt_d = (state_q == ST_OWN0) ? cnt_inc : CNT_W'(1);
        end else if (gnt[PORT_DBG] && lock1_i) begin
            state_d    = ST_OWN1;
            lock_cnt_d = (state_q == ST_OWN1) ? cnt_inc : CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            if (rvalid0_d) rdata0_q <= mem_rdata_i;
            if (rvalid1_d) rdata1_q <= mem_rdata_i;
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

endmodule
